// File: rtl/pipe_stage_chain.sv
// DEPTH-slot valid/ready register chain with flush and bubble collapsing.
// Define PIPE_STAGE_CHAIN_PERF_EN to add saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNTW-1:0]  occupancy
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt
`endif
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [CNTW-1:0]  occ_q;
    logic             in_xfer;
    logic             out_xfer;

    // Slot i advances when any slot at or after it is empty, or the head is being taken.
    for (genvar i = 0; i < DEPTH; i++) begin : g_adv
        assign adv[i] = out_ready | ~(&valid_q[DEPTH-1:i]);
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = valid_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q <= '0;
            occ_q   <= '0;
            // NOTE: payload is reset too, so out_data reads 0 rather than stale data after reset.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            if (adv[0]) begin
                valid_q[0] <= in_valid;
                data_q[0]  <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    data_q[i]  <= data_q[i-1];
                end
            end
            occ_q <= occ_q + CNTW'(in_xfer) - CNTW'(out_xfer);
        end
    end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (out_ready && !out_valid && !flush && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench: three chains (DEPTH 3, 5, 1) against a positional queue model.
module tb_pipe_stage_chain;

    localparam int NI = 3;
    localparam int MAXD = 8;

    logic        CLK;
    logic        RST_N;
    logic        iv   [NI];
    logic        ir   [NI];
    logic [31:0] id   [NI];
    logic        ov   [NI];
    logic        ordy [NI];
    logic [31:0] od   [NI];
    logic        fl   [NI];
    logic [3:0]  occ_w [NI];
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [31:0] stall_w  [NI];
    logic [31:0] bubble_w [NI];
`endif

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D = (g == 0) ? 3 : (g == 1) ? 5 : 1;
        logic [$clog2(D+1)-1:0] occ;
        pipe_stage_chain #(.WIDTH(32), .DEPTH(D)) u_dut (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_data   (id[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_data  (od[g]),
            .flush     (fl[g]),
            .occupancy (occ)
`ifdef PIPE_STAGE_CHAIN_PERF_EN
            ,
            .stall_cnt  (stall_w[g]),
            .bubble_cnt (bubble_w[g])
`endif
        );
        assign occ_w[g] = 4'(occ);
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: each chain is an ordered list of items (oldest first), each with a slot position.
    int          dep [NI] = '{3, 5, 1};
    int          m_cnt [NI];
    logic [31:0] m_dat [NI][MAXD];
    int          m_pos [NI][MAXD];
    bit          m_acc [NI];
    longint      m_stall [NI];
    longint      m_bubble [NI];

    function automatic bit exp_in_ready(int g);
        return !fl[g] && (m_cnt[g] < dep[g] || ordy[g]);
    endfunction

    function automatic bit exp_out_valid(int g);
        return !fl[g] && m_cnt[g] > 0 && m_pos[g][0] == dep[g] - 1;
    endfunction

    task automatic model_step();
        for (int g = 0; g < NI; g++) begin
            bit inx, outx, outv;
            int cap;
            if (!RST_N) begin
                m_cnt[g]    = 0;
                m_acc[g]    = 1'b0;
                m_stall[g]  = 0;
                m_bubble[g] = 0;
                continue;
            end
            outv = exp_out_valid(g);
            inx  = iv[g] && exp_in_ready(g);
            outx = outv && ordy[g];
            m_acc[g] = inx;
            if (outv && !ordy[g] && m_stall[g] < 64'hFFFF_FFFF) m_stall[g]++;
            if (ordy[g] && !outv && !fl[g] && m_bubble[g] < 64'hFFFF_FFFF) m_bubble[g]++;
            if (fl[g]) begin
                m_cnt[g] = 0;
                continue;
            end
            if (outx) begin
                for (int k = 1; k < m_cnt[g]; k++) begin
                    m_dat[g][k-1] = m_dat[g][k];
                    m_pos[g][k-1] = m_pos[g][k];
                end
                m_cnt[g]--;
            end
            // Each item moves one slot on unless it would run into the item ahead.
            cap = dep[g] - 1;
            for (int k = 0; k < m_cnt[g]; k++) begin
                if (m_pos[g][k] + 1 < cap) m_pos[g][k] = m_pos[g][k] + 1;
                else m_pos[g][k] = cap;
                cap = m_pos[g][k] - 1;
            end
            if (inx) begin
                m_dat[g][m_cnt[g]] = id[g];
                m_pos[g][m_cnt[g]] = 0;
                m_cnt[g]++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge CLK);
        if (chk_en) begin
            for (int g = 0; g < NI; g++) begin
                check($sformatf("in_ready%0d", g), 32'(ir[g]), 32'(exp_in_ready(g)));
                check($sformatf("out_valid%0d", g), 32'(ov[g]), 32'(exp_out_valid(g)));
                check($sformatf("occupancy%0d", g), 32'(occ_w[g]), 32'(m_cnt[g]));
                if (exp_out_valid(g)) check($sformatf("out_data%0d", g), od[g], m_dat[g][0]);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
                check($sformatf("stall_cnt%0d", g), stall_w[g], 32'(m_stall[g]));
                check($sformatf("bubble_cnt%0d", g), bubble_w[g], 32'(m_bubble[g]));
`endif
            end
        end
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic idle_all();
        for (int g = 0; g < NI; g++) begin
            iv[g]   = 1'b0;
            id[g]   = '0;
            ordy[g] = 1'b1;
            fl[g]   = 1'b0;
        end
    endtask

    initial begin
        RST_N = 1'b0;
        idle_all();
        for (int g = 0; g < NI; g++) begin
            m_cnt[g] = 0;
            m_acc[g] = 1'b0;
            m_stall[g] = 0;
            m_bubble[g] = 0;
        end
        #1;
        cycle();
        cycle();
        RST_N = 1'b1;
        chk_en = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_out_data%0d", g), od[g], 32'h0);
            check($sformatf("rst_in_ready%0d", g), 32'(ir[g]), 32'd1);
            check($sformatf("rst_occ%0d", g), 32'(occ_w[g]), 32'd0);
        end

        // Streaming through DEPTH=3
        for (int k = 0; k < 3; k++) begin
            iv[0] = 1'b1;
            id[0] = 32'h10 + 32'(k);
            cycle();
        end
        iv[0] = 1'b0;
        check("stream_first", od[0], 32'h10);
        check("stream_peak", 32'(occ_w[0]), 32'd3);
        cycle();
        check("stream_second", od[0], 32'h11);
        cycle();
        check("stream_third", od[0], 32'h12);
        repeat (3) cycle();

        // Back-pressure fill of DEPTH=3
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        id[0] = 32'hA; cycle();
        id[0] = 32'hB; cycle();
        id[0] = 32'hC; cycle();
        id[0] = 32'hD;
        #1;
        check("bp_full_in_ready", 32'(ir[0]), 32'd0);
        cycle();
        check("bp_full_occ", 32'(occ_w[0]), 32'd3);
        ordy[0] = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(ir[0]), 32'd1);
        check("bp_release_head", od[0], 32'hA);
        cycle();
        check("bp_release_occ", 32'(occ_w[0]), 32'd3);
        check("bp_next_head", od[0], 32'hB);
        iv[0] = 1'b0;
        repeat (4) cycle();

        // Flush of DEPTH=5 with 4 items in flight
        ordy[1] = 1'b0;
        iv[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            id[1] = 32'h100 + 32'(k);
            cycle();
        end
        id[1] = 32'h200;
        fl[1] = 1'b1;
        #1;
        check("flush_in_ready", 32'(ir[1]), 32'd0);
        check("flush_out_valid", 32'(ov[1]), 32'd0);
        cycle();
        fl[1] = 1'b0;
        #1;
        check("post_flush_occ", 32'(occ_w[1]), 32'd0);
        check("post_flush_out_valid", 32'(ov[1]), 32'd0);
        check("post_flush_in_ready", 32'(ir[1]), 32'd1);
        cycle();
        check("post_flush_accept", 32'(occ_w[1]), 32'd1);
        iv[1] = 1'b0;
        ordy[1] = 1'b1;
        repeat (6) cycle();

        // Reset while DEPTH=5 is full, together with flush and out_ready
        ordy[1] = 1'b0;
        iv[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            id[1] = 32'h300 + 32'(k);
            cycle();
        end
        iv[1] = 1'b0;
        check("full_occ", 32'(occ_w[1]), 32'd5);
        RST_N = 1'b0;
        fl[1] = 1'b1;
        ordy[1] = 1'b1;
        cycle();
        RST_N = 1'b1;
        fl[1] = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(ov[1]), 32'd0);
        check("rst_mid_out_data", od[1], 32'h0);
        check("rst_mid_occ", 32'(occ_w[1]), 32'd0);
        check("rst_mid_in_ready", 32'(ir[1]), 32'd1);
        cycle();

`ifdef PIPE_STAGE_CHAIN_PERF_EN
        begin
            logic [31:0] s0, b0;
            ordy[0] = 1'b0;
            iv[0] = 1'b1;
            id[0] = 32'h55;
            cycle();
            iv[0] = 1'b0;
            repeat (2) cycle();
            s0 = stall_w[0];
            repeat (7) cycle();
            check("perf_stall7", stall_w[0] - s0, 32'd7);
            ordy[0] = 1'b1;
            cycle();
            b0 = bubble_w[0];
            repeat (4) cycle();
            check("perf_bubble4", bubble_w[0] - b0, 32'd4);
        end
`endif

        // Randomized traffic; the DEPTH=1 chain alternates out_ready every cycle.
        for (int c = 0; c < 3000; c++) begin
            for (int g = 0; g < NI; g++) begin
                if (!(iv[g] && !m_acc[g])) begin
                    iv[g] = ($urandom_range(0, 3) != 0);
                    id[g] = $urandom;
                end
                if (g == 2) ordy[g] = c[0];
                else ordy[g] = ($urandom_range(0, 2) != 0);
                fl[g] = ($urandom_range(0, 31) == 0);
            end
            cycle();
        end

        idle_all();
        repeat (8) cycle();
        for (int g = 0; g < NI; g++) begin
            check($sformatf("drained%0d", g), 32'(occ_w[g]), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
